// File: rtl/xeta_decrypt.sv
// XETA block decryptor: one half-round per cycle, start/busy/valid handshake.
// Recovers the {v0, v1} block produced by the matching xeta_1 encryptor.
module xeta_decrypt #(
  parameter int            w      = 16,
  parameter int            ROUNDS = 32,
  parameter logic [w-1:0]  DELTA  = 16'h9E37
) (
  input  logic             clock,
  input  logic             reset1,
  input  logic [w-1:0]     K_i,
  input  logic [1:0]       key_addr,
  input  logic             write_Ki,
  input  logic [2*w-1:0]   C_in,
  input  logic             start,
  output logic             busy,
  output logic             P_valid,
  output logic [2*w-1:0]   P
);

  localparam logic [w-1:0] SUM_INIT = w'(DELTA * w'(ROUNDS));
  localparam logic [7:0]   RND_LAST = 8'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, HALF1, HALF0, DONE} state_t;

  state_t         state_q, state_d;
  logic [w-1:0]   v0_q, v0_d;
  logic [w-1:0]   v1_q, v1_d;
  logic [w-1:0]   sum_q, sum_d;
  logic [7:0]     rnd_q, rnd_d;
  logic [2*w-1:0] p_q, p_d;
  logic [w-1:0]   key_q [4];
  logic [w-1:0]   key_d [4];

  function automatic logic [w-1:0] f(input logic [w-1:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    rnd_d   = rnd_q;
    p_d     = p_q;
    for (int unsigned i = 0; i < 4; i++) key_d[i] = key_q[i];

    case (state_q)
      IDLE: begin
        if (write_Ki) key_d[key_addr] = K_i;
        if (start) begin
          v0_d    = C_in[2*w-1:w];
          v1_d    = C_in[w-1:0];
          sum_d   = SUM_INIT;
          rnd_d   = '0;
          state_d = HALF1;
        end
      end
      HALF1: begin
        v1_d    = v1_q - (f(v0_q) ^ (sum_q + key_q[sum_q[w-1:w-2]]));
        sum_d   = sum_q - DELTA;
        state_d = HALF0;
      end
      HALF0: begin
        v0_d = v0_q - (f(v1_q) ^ (sum_q + key_q[sum_q[1:0]]));
        if (rnd_q == RND_LAST) begin
          // P is captured on entry to DONE so it is already valid while P_valid is high.
          p_d     = {v0_d, v1_q};
          state_d = DONE;
        end else begin
          rnd_d   = rnd_q + 8'd1;
          state_d = HALF1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset1) begin
    if (reset1) begin
      state_q <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      rnd_q   <= '0;
      p_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) key_q[i] <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      rnd_q   <= rnd_d;
      p_q     <= p_d;
      for (int unsigned i = 0; i < 4; i++) key_q[i] <= key_d[i];
    end
  end

  assign busy    = (state_q != IDLE);
  assign P_valid = (state_q == DONE);
  assign P       = p_q;

endmodule

// File: tb/tb_xeta_decrypt.sv
// Bench for xeta_decrypt: blocks enciphered by an XTEA-style reference model are
// decrypted by the DUT (default and single-round builds) and checked for plaintext and timing.
module tb_xeta_decrypt;

  localparam logic [15:0] DELTA = 16'h9E37;

  logic        clock = 1'b0;
  logic        reset1;
  logic [15:0] K_i;
  logic [1:0]  key_addr;
  logic        write_Ki;
  logic [31:0] C_in;
  logic        start;
  logic        busy, P_valid;
  logic [31:0] P;

  logic [15:0] K_i1;
  logic [1:0]  key_addr1;
  logic        write_Ki1;
  logic [31:0] C_in1;
  logic        start1;
  logic        busy1, P_valid1;
  logic [31:0] P1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  xeta_decrypt dut (
    .clock(clock), .reset1(reset1), .K_i(K_i), .key_addr(key_addr), .write_Ki(write_Ki),
    .C_in(C_in), .start(start), .busy(busy), .P_valid(P_valid), .P(P)
  );

  xeta_decrypt #(.ROUNDS(1)) dut1 (
    .clock(clock), .reset1(reset1), .K_i(K_i1), .key_addr(key_addr1), .write_Ki(write_Ki1),
    .C_in(C_in1), .start(start1), .busy(busy1), .P_valid(P_valid1), .P(P1)
  );

  function automatic logic [15:0] fm(input logic [15:0] x);
    logic [15:0] a, b;
    a = x << 4;
    b = x >> 5;
    return (a ^ b) + x;
  endfunction

  // xeta_1 encryption: v0 half then v1 half, sum advancing by DELTA each round
  function automatic logic [31:0] encrypt(input int rounds, input logic [3:0][15:0] k,
                                          input logic [31:0] pt);
    logic [15:0] v0, v1, sum;
    v0 = pt[31:16];
    v1 = pt[15:0];
    sum = 16'h0000;
    for (int r = 0; r < rounds; r++) begin
      v0  = v0 + (fm(v1) ^ (sum + k[sum[1:0]]));
      sum = sum + DELTA;
      v1  = v1 + (fm(v0) ^ (sum + k[sum[15:14]]));
    end
    return {v0, v1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_key(input logic [3:0][15:0] k);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      write_Ki = 1'b1;
      key_addr = 2'(i);
      K_i      = k[i];
    end
    @(negedge clock);
    write_Ki = 1'b0;
  endtask

  task automatic run_block(input logic [31:0] ct, input logic [31:0] exp_pt, input string tag);
    int n;
    bit seen;
    @(negedge clock);
    C_in  = ct;
    start = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (P_valid) seen = 1;
    end
    check({tag, "_latency"}, 32'(n), 32'd65);
    check({tag, "_sum_zero"}, 32'(dut.sum_q), 32'd0);
    check({tag, "_P"}, P, exp_pt);
  endtask

  task automatic run_block1(input logic [31:0] ct, input logic [31:0] exp_pt, input string tag);
    int n;
    bit seen;
    @(negedge clock);
    C_in1  = ct;
    start1 = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      start1 = 1'b0;
      n++;
      if (P_valid1) seen = 1;
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_P"}, P1, exp_pt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [3:0][15:0] key, zkey;
    logic [31:0] pt, ct;
    int n, pulses, lat;
    int pt_at [3];
    bit stable;
    logic [31:0] p_first;

    zkey = '0;
    reset1 = 1'b1;
    K_i = '0; key_addr = '0; write_Ki = 1'b0; C_in = '0; start = 1'b0;
    K_i1 = '0; key_addr1 = '0; write_Ki1 = 1'b0; C_in1 = '0; start1 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(P_valid), 32'd0);
    check("rst_P", P, 32'd0);
    check("rst_P_r1", P1, 32'd0);
    reset1 = 1'b0;

    // single-round build, zero key
    run_block1(32'h0000_0000, 32'h7E99_61C9, "r1_zero");
    ct = encrypt(1, zkey, 32'h7E99_61C9);
    run_block1(ct, 32'h7E99_61C9, "r1_roundtrip");

    // random key/plaintext round trips
    for (int i = 0; i < 200; i++) begin
      for (int j = 0; j < 4; j++) key[j] = 16'($urandom);
      pt = $urandom;
      write_key(key);
      run_block(encrypt(32, key, pt), pt, "rand");
    end
    @(negedge clock);
    check("valid_one_cycle", 32'(P_valid), 32'd0);

    // key write and start while busy must both be ignored
    for (int j = 0; j < 4; j++) key[j] = 16'($urandom);
    key[2] = 16'h1234;
    pt = $urandom;
    write_key(key);
    @(negedge clock);
    C_in  = encrypt(32, key, pt);
    start = 1'b1;
    pulses = 0; lat = -1; p_first = '0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clock);
      start    = 1'b0;
      write_Ki = 1'b0;
      if (c == 10) begin
        write_Ki = 1'b1; key_addr = 2'd2; K_i = 16'hFFFF; start = 1'b1;
        C_in = 32'hDEAD_BEEF;
      end
      if (P_valid) begin
        pulses++;
        if (pulses == 1) begin lat = c; p_first = P; end
      end
    end
    write_Ki = 1'b0;
    start = 1'b0;
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_latency", 32'(lat), 32'd65);
    check("busy_P", p_first, pt);
    pt = $urandom;
    run_block(encrypt(32, key, pt), pt, "busy_key_kept");

    // reset during round 10
    @(negedge clock);
    C_in  = encrypt(32, key, pt);
    start = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    reset1 = 1'b1;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_P", P, 32'd0);
    check("abort_valid", 32'(P_valid), 32'd0);
    reset1 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (P_valid) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 32'd0);
    pt = $urandom;
    run_block(encrypt(32, zkey, pt), pt, "post_reset_zero_key");

    // start held high: three back-to-back blocks
    pt = $urandom;
    @(negedge clock);
    C_in  = encrypt(32, zkey, pt);
    start = 1'b1;
    pulses = 0;
    stable = 1;
    for (int k = 0; k < 3; k++) pt_at[k] = -1000;
    n = 0;
    while (pulses < 3 && n < 300) begin
      @(negedge clock);
      n++;
      if (P_valid) begin
        pt_at[pulses] = n;
        pulses++;
        check("held_P", P, pt);
        if (pulses == 3) start = 1'b0;
      end else if (pulses >= 1 && P !== pt) begin
        stable = 0;
      end
    end
    start = 1'b0;
    check("held_first", 32'(pt_at[0]), 32'd65);
    check("held_spacing1", 32'(pt_at[1] - pt_at[0]), 32'd66);
    check("held_spacing2", 32'(pt_at[2] - pt_at[1]), 32'd66);
    check("held_P_stable", 32'(stable), 32'd1);
    for (int c = 0; c < 4; c++) @(negedge clock);
    check("held_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xeta_decrypt.md
Name: xeta_decrypt

Overview:
- Decryption counterpart of the `xeta_1` encryption datapath. Accepts a 2w-bit ciphertext block and a 4-word key, and runs the inverse XETA (XTEA-style) round function to recover the plaintext.
- Sits on the receive side of the link. Its output must equal the `{V0, V1}` block originally fed to the encryptor.
- Processes one half-round per cycle under a small control FSM with a start/busy/valid handshake.

Parameters:
- w, 16, word width; block is 2w bits, key is 4 words of w bits.
- ROUNDS, 32, number of full rounds; legal range 1..255.
- DELTA, 16'h9E37, round constant, w bits.
- SUM_INIT = (DELTA*ROUNDS) mod 2^w is derived locally, not a parameter; default value 16'hC6E0.

Ports:
- clock  in  1  rising-edge clock
- reset1  in  1  asynchronous, active-high reset
- K_i  in  w  key word to write
- key_addr  in  2  key word index 0..3
- write_Ki  in  1  key write strobe
- C_in  in  2w  ciphertext {v0, v1}, v0 in the upper w bits
- start  in  1  begin decryption of C_in
- busy  out  1  high while a block is in progress
- P_valid  out  1  one-cycle pulse when P is updated
- P  out  2w  plaintext {v0, v1}, held until the next completion

Behaviour:
- Reset (async, reset1=1): state=IDLE; busy=0; P_valid=0; P=0; v0, v1, sum and round counter cleared; key registers cleared to 0.
- Key write: in IDLE with write_Ki=1, key[key_addr]<=K_i. write_Ki is ignored in any other state.
- f(x) = ((x<<4) ^ (x>>5)) + x. All arithmetic is mod 2^w; shifts are logical.
- FSM states: IDLE, HALF1, HALF0, DONE.
- IDLE:
  - busy=0.
  - start=1 latches v0=C_in[2w-1:w], v1=C_in[w-1:0], sum=SUM_INIT, rnd=0, then goes to HALF1.
  - If start and write_Ki are both high, the key write happens and start is also accepted.
- HALF1:
  - v1 <= v1 - (f(v0) ^ (sum + key[sum[w-1:w-2]])).
  - sum <= sum - DELTA.
  - Next state is HALF0.
- HALF0:
  - v0 <= v0 - (f(v1) ^ (sum + key[sum[1:0]])), using the already-decremented sum and the updated v1.
  - If rnd==ROUNDS-1, go to DONE; otherwise rnd++ and go to HALF1.
- DONE:
  - P <= {v0, v1}; P_valid=1 for exactly this cycle; next state is IDLE.
- busy=1 in HALF1, HALF0 and DONE. start is ignored while busy=1.
- Latency: start sampled at edge t gives P_valid high in the cycle after edge t+2*ROUNDS. For the default ROUNDS, that is 65 cycles from start to P_valid. Back-to-back throughput is one block per 2*ROUNDS+2 cycles.
- After the final HALF0, sum must equal 0. The bench checks this internal invariant.
- Reset mid-operation: the block returns to IDLE immediately, P=0, and the key is lost. No P_valid is produced for the aborted block.
- P, and the key registers, hold their values between blocks. start asserted continuously re-triggers one cycle after each return to IDLE.

Test Plan:
- ROUNDS=1, key all 0, C_in=32'h0000_0000, start -> after 3 cycles P_valid=1, P=32'h7E99_61C9.
- ROUNDS=1, key all 0, C_in=32'h7E99_61C9 fed to `xeta_1`-equivalent encryption, then that ciphertext decrypted -> P=32'h7E99_61C9. This is a round-trip sanity check of the key index mapping.
- Default params, 200 random key/plaintext pairs encrypted by a `xeta_1` bench model and decrypted here:
  - P must equal the original plaintext.
  - P_valid must rise exactly 65 cycles after start.
  - Internal sum must be 0 at DONE.
- While busy, write_Ki=1 with key_addr=2, K_i=16'hFFFF, and start pulsed -> both ignored; result matches the unmodified-key model; only one P_valid.
- Assert reset1 during round 10 -> busy=0, P=0, P_valid never pulses. A new start after release decrypts correctly, and the key reads back as zero-key behaviour.
- start held high for 3 blocks -> P_valid pulses spaced 66 cycles apart; P stable between pulses.
